// File: rtl/seg_scan_display_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Segment constants are {CA..CG}, active-low.
package seg_scan_display_pkg;

    localparam logic [4:0] BLANK_CODE = 5'h1F;

    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h60;
    localparam logic [6:0] SEG_C     = 7'h31;
    localparam logic [6:0] SEG_D     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h30;
    localparam logic [6:0] SEG_F     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic MODE_SHIFT = 1'b0;
    localparam logic MODE_ADDR  = 1'b1;

    typedef enum logic {
        StIdle   = 1'b0,
        StCommit = 1'b1
    } in_state_e;

    function automatic logic [4:0] nibble_code(input logic [3:0] nibble);
        return {1'b0, nibble};
    endfunction

endpackage

// File: rtl/seg_scan_display_seg7_decode.sv
// Combinational decode of a 5-bit {blank,hex} digit code to active-low segments.
// Codes 5'h10..5'h1F all render blank.
module seg_scan_display_seg7_decode
    import seg_scan_display_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            5'h00:   seg_o = SEG_0;
            5'h01:   seg_o = SEG_1;
            5'h02:   seg_o = SEG_2;
            5'h03:   seg_o = SEG_3;
            5'h04:   seg_o = SEG_4;
            5'h05:   seg_o = SEG_5;
            5'h06:   seg_o = SEG_6;
            5'h07:   seg_o = SEG_7;
            5'h08:   seg_o = SEG_8;
            5'h09:   seg_o = SEG_9;
            5'h0A:   seg_o = SEG_A;
            5'h0B:   seg_o = SEG_B;
            5'h0C:   seg_o = SEG_C;
            5'h0D:   seg_o = SEG_D;
            5'h0E:   seg_o = SEG_E;
            5'h0F:   seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver: byte handshake into a digit buffer (shift or addressed
// write), time-multiplexed scan with per-digit decimal point and blink.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 8,
    parameter int unsigned REFRESH_CNT = 200000,
    parameter int unsigned BLINK_CNT   = 25,
    localparam int unsigned AW = (N_DIGITS > 2) ? $clog2(N_DIGITS / 2) : 1,
    localparam int unsigned IW = $clog2(N_DIGITS),
    localparam int unsigned RW = $clog2(REFRESH_CNT),
    localparam int unsigned BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          data_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                mode_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic                clear_i,
    input  logic [N_DIGITS-1:0] dp_mask_i,
    input  logic [N_DIGITS-1:0] blink_mask_i,
    output logic [7:0]          byte_cnt_o,
    output logic [N_DIGITS-1:0] led_en_o,
    output logic [7:0]          led_cx_o
);

    in_state_e     state_q;
    logic          ready_q;
    logic [7:0]    data_q;
    logic          mode_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    byte_cnt_q;
    logic [4:0]    buf_q  [N_DIGITS];
    logic [4:0]    buf_wr [N_DIGITS];

    logic [RW-1:0]       ref_q, ref_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BW-1:0]       blink_q, blink_d;
    logic                phase_q, phase_d;
    logic [N_DIGITS-1:0] led_en_q, led_en_d;
    logic [7:0]          led_cx_q, led_cx_d;
    logic [4:0]          scan_code;
    logic [6:0]          scan_seg;

    // clear must win over a same-cycle offer, so it gates ready combinationally.
    assign ready_o    = ready_q & ~clear_i;
    assign byte_cnt_o = byte_cnt_q;
    assign led_en_o   = led_en_q;
    assign led_cx_o   = led_cx_q;

    always_comb begin
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            buf_wr[i] = buf_q[i];
        end
        if (mode_q == MODE_SHIFT) begin
            for (int i = 2; i < int'(N_DIGITS); i++) begin
                buf_wr[i] = buf_q[i-2];
            end
            buf_wr[1] = nibble_code(data_q[7:4]);
            buf_wr[0] = nibble_code(data_q[3:0]);
        end else begin
            // Out-of-range pair addresses match no k and leave the buffer untouched.
            for (int unsigned k = 0; k < N_DIGITS / 2; k++) begin
                if (32'(addr_q) == k) begin
                    buf_wr[2*k+1] = nibble_code(data_q[7:4]);
                    buf_wr[2*k]   = nibble_code(data_q[3:0]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ready_q    <= 1'b1;
            data_q     <= 8'h00;
            mode_q     <= MODE_SHIFT;
            addr_q     <= '0;
            byte_cnt_q <= 8'h00;
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                buf_q[i] <= BLANK_CODE;
            end
        end else if (clear_i) begin
            state_q    <= StIdle;
            ready_q    <= 1'b1;
            byte_cnt_q <= 8'h00;
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                buf_q[i] <= BLANK_CODE;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid_i) begin
                        data_q  <= data_i;
                        mode_q  <= mode_i;
                        addr_q  <= wr_addr_i;
                        ready_q <= 1'b0;
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    for (int i = 0; i < int'(N_DIGITS); i++) begin
                        buf_q[i] <= buf_wr[i];
                    end
                    if (byte_cnt_q != 8'hFF) begin
                        byte_cnt_q <= byte_cnt_q + 8'h01;
                    end
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        ref_d   = ref_q + RW'(1);
        idx_d   = idx_q;
        blink_d = blink_q;
        phase_d = phase_q;
        if (ref_q == RW'(REFRESH_CNT - 1)) begin
            ref_d = '0;
            if (idx_q == IW'(N_DIGITS - 1)) begin
                idx_d = '0;
                if (blink_q == BW'(BLINK_CNT - 1)) begin
                    blink_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    assign scan_code = buf_q[idx_q];

    seg_scan_display_seg7_decode u_seg7_decode (
        .code_i (scan_code),
        .seg_o  (scan_seg)
    );

    always_comb begin
        led_en_d = ~(N_DIGITS'(1) << idx_q);
        if (blink_mask_i[idx_q] && !phase_q) begin
            led_cx_d = 8'hFF;
        end else begin
            led_cx_d = {scan_seg, ~dp_mask_i[idx_q]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q    <= '0;
            idx_q    <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b1;
            led_en_q <= '1;
            led_cx_q <= 8'hFF;
        end else begin
            ref_q    <= ref_d;
            idx_q    <= idx_d;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
            led_en_q <= led_en_d;
            led_cx_q <= led_cx_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with N_DIGITS=8, REFRESH_CNT=4, BLINK_CNT=2.
module tb_seg_scan_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       mode;
    logic [1:0] wr_addr;
    logic       clear;
    logic [7:0] dp_mask;
    logic [7:0] blink_mask;
    logic [7:0] byte_cnt;
    logic [7:0] led_en;
    logic [7:0] led_cx;

    int passed = 0;
    int total  = 0;

    logic [4:0]  mdl_buf [8];
    int          mdl_cnt;
    logic [7:0]  cnt_q  [$];
    logic [15:0] scan_q [$];

    seg_scan_display #(
        .N_DIGITS    (8),
        .REFRESH_CNT (4),
        .BLINK_CNT   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data),
        .valid_i      (valid),
        .ready_o      (ready),
        .mode_i       (mode),
        .wr_addr_i    (wr_addr),
        .clear_i      (clear),
        .dp_mask_i    (dp_mask),
        .blink_mask_i (blink_mask),
        .byte_cnt_o   (byte_cnt),
        .led_en_o     (led_en),
        .led_cx_o     (led_cx)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [4:0] c);
        case (c)
            5'h00: return 7'h01;  5'h01: return 7'h4F;  5'h02: return 7'h12;
            5'h03: return 7'h06;  5'h04: return 7'h4C;  5'h05: return 7'h24;
            5'h06: return 7'h20;  5'h07: return 7'h0F;  5'h08: return 7'h00;
            5'h09: return 7'h04;  5'h0A: return 7'h08;  5'h0B: return 7'h60;
            5'h0C: return 7'h31;  5'h0D: return 7'h42;  5'h0E: return 7'h30;
            5'h0F: return 7'h38;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [7:0] exp_cx(input int d, input bit phase_on);
        if (blink_mask[d] && !phase_on) return 8'hFF;
        return {seg_of(mdl_buf[d]), ~dp_mask[d]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl_buf[i] = 5'h1F;
        mdl_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic m, input logic [1:0] a);
        int w = 0;
        @(negedge clk);
        while (ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        total++;
        if (ready !== 1'b1) $display("FAIL ready_before: got %b want 1", ready);
        else passed++;
        data = d; mode = m; wr_addr = a; valid = 1'b1;
        if (m == 1'b0) begin
            for (int i = 7; i >= 2; i--) mdl_buf[i] = mdl_buf[i-2];
            mdl_buf[1] = {1'b0, d[7:4]};
            mdl_buf[0] = {1'b0, d[3:0]};
        end else begin
            mdl_buf[2*a+1] = {1'b0, d[7:4]};
            mdl_buf[2*a]   = {1'b0, d[3:0]};
        end
        if (mdl_cnt < 255) mdl_cnt++;
        cnt_q.push_back(8'(mdl_cnt));
        @(negedge clk);
        valid = 1'b0;
        total++;
        if (ready !== 1'b0) $display("FAIL ready_low: got %b want 0", ready);
        else passed++;
        @(negedge clk);
        total++;
        if (ready !== 1'b1) $display("FAIL ready_back: got %b want 1", ready);
        else passed++;
        begin
            logic [7:0] exp_cnt;
            exp_cnt = cnt_q.pop_front();
            total++;
            if (byte_cnt !== exp_cnt) $display("FAIL byte_cnt: got %h want %h", byte_cnt, exp_cnt);
            else passed++;
        end
    endtask

    task automatic wait_frame_start(output bit ok);
        int w = 0;
        while (led_en === 8'hFE && w < 200) begin
            @(negedge clk);
            w++;
        end
        while (led_en !== 8'hFE && w < 200) begin
            @(negedge clk);
            w++;
        end
        ok = (w < 200);
    endtask

    task automatic check_frame(input string name, input bit phase_on);
        bit          ok;
        logic [15:0] exp;
        wait_frame_start(ok);
        total++;
        if (!ok) $display("FAIL %s_sync: led_en got %h want fe within bound", name, led_en);
        else passed++;
        for (int d = 0; d < 8; d++) begin
            logic [7:0] en_e;
            en_e = ~(8'(1) << d);
            scan_q.push_back({en_e, exp_cx(d, phase_on)});
        end
        for (int d = 0; d < 8; d++) begin
            exp = scan_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                total += 2;
                if (led_en !== exp[15:8])
                    $display("FAIL %s_en d%0d: got %h want %h", name, d, led_en, exp[15:8]);
                else passed++;
                if (led_cx !== exp[7:0])
                    $display("FAIL %s_cx d%0d: got %h want %h", name, d, led_cx, exp[7:0]);
                else passed++;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total += 4;
        if (led_en !== 8'hFF) $display("FAIL %s_en: got %h want ff", name, led_en);
        else passed++;
        if (led_cx !== 8'hFF) $display("FAIL %s_cx: got %h want ff", name, led_cx);
        else passed++;
        if (ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", name, ready);
        else passed++;
        if (byte_cnt !== 8'h00) $display("FAIL %s_cnt: got %h want 00", name, byte_cnt);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; data = 8'h00; mode = 1'b0; wr_addr = 2'd0;
        clear = 1'b0; dp_mask = 8'h00; blink_mask = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        check_frame("scan_blank", 1'b1);
    endtask

    task automatic test_shift();
        send_byte(8'h12, 1'b0, 2'd0);
        send_byte(8'h34, 1'b0, 2'd0);
        check_frame("shift2", 1'b1);
    endtask

    task automatic test_shift_overflow();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_reset();
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b0, 2'd0);
        total++;
        if (byte_cnt !== 8'd5) $display("FAIL shift5_cnt: got %0d want 5", byte_cnt);
        else passed++;
        check_frame("shift5", 1'b1);
    endtask

    task automatic test_addressed();
        send_byte(8'hAB, 1'b1, 2'd2);
        check_frame("addr2", 1'b1);
        dp_mask = 8'h80;
        send_byte(8'hCD, 1'b1, 2'd3);
        check_frame("addr3_dp", 1'b1);
    endtask

    task automatic test_clear_vs_valid();
        @(negedge clk);
        dp_mask = 8'h00;
        clear = 1'b1; valid = 1'b1; data = 8'h77; mode = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0) $display("FAIL clear_ready: got %b want 0", ready);
        else passed++;
        @(negedge clk);
        clear = 1'b0; valid = 1'b0;
        model_reset();
        total++;
        if (byte_cnt !== 8'h00) $display("FAIL clear_cnt: got %h want 00", byte_cnt);
        else passed++;
        @(negedge clk);
        total++;
        if (byte_cnt !== 8'h00) $display("FAIL clear_cnt_after: got %h want 00", byte_cnt);
        else passed++;
        check_frame("clear", 1'b1);
    endtask

    task automatic test_blink_and_reset();
        bit          ok;
        logic [15:0] exp;
        @(negedge clk); rst = 1'b1; blink_mask = 8'h00;
        @(negedge clk); rst = 1'b0;
        model_reset();
        wait_frame_start(ok);
        send_byte(8'h05, 1'b0, 2'd0);
        blink_mask = 8'h01;
        for (int f = 1; f <= 5; f++) begin
            wait_frame_start(ok);
            total++;
            if (!ok) $display("FAIL blink_sync f%0d: led_en got %h want fe", f, led_en);
            else passed++;
            scan_q.push_back({8'hFE, exp_cx(0, ((f / 2) % 2) == 0)});
            exp = scan_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                total++;
                if (led_cx !== exp[7:0])
                    $display("FAIL blink_cx f%0d: got %h want %h", f, led_cx, exp[7:0]);
                else passed++;
                @(negedge clk);
            end
        end
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_shift();
        test_shift_overflow();
        test_addressed();
        test_clear_vs_valid();
        test_blink_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
